load_store_unit: RTL and testbench

Sits between the CPU execute stage and the memory bus, converting RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned bus transactions. For stores it produces byte-lane data and an active-low write mask. For loads it produces extracted, sign- or zero-extended results. It owns the bus handshake: hold enable until ready, then drop enable for one recovery cycle. It also rejects misaligned accesses and aborts stalled transfers with a timeout.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store to word-aligned bus bridge
// Lane shifting for stores, extraction/extension for loads, bus handshake with timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] address_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        error_o,
  output logic        busy_o,
  output logic [15:0] bus_address_o,
  output logic [31:0] bus_data_out_o,
  output logic [3:0]  bus_write_mask_o,
  output logic        bus_enable_o,
  output logic        bus_write_enable_o,
  input  logic [31:0] bus_data_read_i,
  input  logic        bus_data_ready_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RECOVER = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] load_q, load_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        illegal, misaligned;
  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic [31:0] shifted;
  logic [31:0] extracted;
  logic        unused_addr;

  assign unused_addr = ^address_i[31:16];

  assign illegal    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                      (is_store_i && funct3_i[2]);
  assign misaligned = ((funct3_i[1:0] == 2'b01) && address_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (address_i[1:0] != 2'b00));

  always_comb begin
    lane_data = 32'd0;
    lane_mask = 4'b1111;
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          lane_data = {24'd0, store_data_i[7:0]} << {address_i[1:0], 3'b000};
          lane_mask = ~(4'b0001 << address_i[1:0]);
        end
        2'b01: begin
          lane_data = {16'd0, store_data_i[15:0]} << {address_i[1:0], 3'b000};
          lane_mask = ~(4'b0011 << address_i[1:0]);
        end
        default: begin
          lane_data = store_data_i;
          lane_mask = 4'b0000;
        end
      endcase
    end
  end

  // Extraction uses the offset and size latched at request time, not the live inputs.
  assign shifted = bus_data_read_i >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extracted = {24'd0, shifted[7:0]};
      3'b101:  extracted = {16'd0, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load_d  = load_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d = 8'd0;
          if (illegal || misaligned) begin
            state_d = RECOVER;
            err_d   = 1'b1;
            load_d  = 32'd0;
          end else begin
            state_d = BUS;
            err_d   = 1'b0;
            addr_d  = {address_i[15:2], 2'b00};
            wdata_d = lane_data;
            mask_d  = lane_mask;
            we_d    = is_store_i;
            f3_d    = funct3_i;
            off_d   = address_i[1:0];
          end
        end
      end
      BUS: begin
        if (bus_data_ready_i) begin
          state_d = RECOVER;
          err_d   = 1'b0;
          load_d  = we_q ? 32'd0 : extracted;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = RECOVER;
          err_d   = 1'b1;
          load_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      load_q  <= 32'd0;
      addr_q  <= 16'd0;
      wdata_q <= 32'd0;
      mask_q  <= 4'b1111;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign bus_enable_o       = (state_q == BUS);
  assign bus_write_enable_o = bus_enable_o & we_q;
  assign busy_o             = (state_q != IDLE);
  assign done_o             = (state_q == RECOVER);
  assign error_o            = err_q;
  assign load_data_o        = load_q;
  assign bus_address_o      = addr_q;
  assign bus_data_out_o     = wdata_q;
  assign bus_write_mask_o   = mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
// Directed plus random load/store requests against a byte-lane reference model.
module tb_load_store_unit;
  localparam int T = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] load_data;
  logic        done, error, busy;
  logic [15:0] bus_address;
  logic [31:0] bus_data_out;
  logic [3:0]  bus_write_mask;
  logic        bus_enable, bus_write_enable;
  logic [31:0] bus_data_read = 32'd0;
  logic        bus_data_ready = 1'b0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .is_store_i(is_store),
    .funct3_i(funct3), .address_i(address), .store_data_i(store_data),
    .load_data_o(load_data), .done_o(done), .error_o(error), .busy_o(busy),
    .bus_address_o(bus_address), .bus_data_out_o(bus_data_out),
    .bus_write_mask_o(bus_write_mask), .bus_enable_o(bus_enable),
    .bus_write_enable_o(bus_write_enable), .bus_data_read_i(bus_data_read),
    .bus_data_ready_i(bus_data_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] ld;
    bit          chk_ld;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        we;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   bcnt = 0;
  int   rdy_delay = 0;
  logic [31:0] rd_word = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: expected completion and bus transaction from the access rules.
  function automatic void model(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                                input bit [31:0] sd, input bit [31:0] word, input int dly,
                                output exp_t e, output bit go_bus, output bus_t b);
    int size;
    bit sgn;
    bit legal;
    int off;
    longint unsigned v;
    size = 4; sgn = 0; legal = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: legal = 0;
    endcase
    if (st && f3 >= 3'd4) legal = 0;
    off = int'(addr % 4);
    e.t0 = 0;
    b.a = addr[15:0] & 16'hFFFC;
    b.we = st;
    b.d = 32'd0;
    b.m = 4'b1111;
    if (!legal || (off % size) != 0) begin
      go_bus = 0; e.err = 1; e.ld = 32'd0; e.chk_ld = 0; e.lat = 1;
      return;
    end
    go_bus = 1;
    if (st) begin
      v = (longint'(sd) % (64'd1 << (8 * size))) * (64'd1 << (8 * off));
      b.d = v[31:0];
      for (int i = 0; i < 4; i++) b.m[i] = !(i >= off && i < off + size);
    end
    v = (longint'(word) / (64'd1 << (8 * off))) % (64'd1 << (8 * size));
    if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
    if (dly <= T) begin
      e.err = 0; e.lat = dly + 1; e.ld = v[31:0]; e.chk_ld = !st;
    end else begin
      e.err = 1; e.lat = T + 1; e.ld = 32'd0; e.chk_ld = 1;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus_enable) bcnt = bcnt + 1;
      else bcnt = 0;
      bus_data_ready = bus_enable ? (bcnt == rdy_delay) : 1'($urandom_range(0, 1));
      bus_data_read = rd_word;
    end
  end

  initial begin
    bus_t cur;
    cur = '{a: 16'd0, d: 32'd0, m: 4'hF, we: 1'b0};
    forever begin
      @(negedge clk);
      if (rst_n && bus_enable) begin
        if (bcnt == 1) begin
          check("bus_access_expected", 32'(bus_q.size() != 0), 32'd1);
          if (bus_q.size() != 0) cur = bus_q.pop_front();
        end
        check("bus_address", 32'(bus_address), 32'(cur.a));
        check("bus_write_mask", 32'(bus_write_mask), 32'(cur.m));
        check("bus_write_enable", 32'(bus_write_enable), 32'(cur.we));
        if (cur.we) check("bus_data_out", bus_data_out, cur.d);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("error", 32'(error), 32'(e.err));
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
          check("busy_at_done", 32'(busy), 32'd1);
          check("bus_enable_at_done", 32'(bus_enable), 32'd0);
          if (e.chk_ld) check("load_data", load_data, e.ld);
        end
      end
    end
  end

  task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] sd, input bit [31:0] word, input int dly);
    exp_t e;
    bus_t b;
    bit go;
    model(st, f3, addr, sd, word, dly, e, go, b);
    @(posedge clk);
    #1;
    e.t0 = cyc;
    exp_q.push_back(e);
    if (go) bus_q.push_back(b);
    rdy_delay = dly;
    rd_word = word;
    is_store = st; funct3 = f3; address = addr; store_data = sd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    address = $urandom; store_data = $urandom;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic op(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                    input bit [31:0] sd, input bit [31:0] word, input int dly);
    issue(st, f3, addr, sd, word, dly);
    wait_done();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bus_enable"}, 32'(bus_enable), 32'd0);
    check({tag, "_bus_write_enable"}, 32'(bus_write_enable), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_load_data"}, load_data, 32'd0);
    check({tag, "_bus_address"}, 32'(bus_address), 32'd0);
    check({tag, "_bus_data_out"}, bus_data_out, 32'd0);
    check({tag, "_bus_write_mask"}, 32'(bus_write_mask), 32'hF);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_values("reset");
    rst_n = 1'b1;

    op(0, 3'd2, 32'h0000_0008, 32'd0, 32'hDEAD_BEEF, 9);
    op(0, 3'd0, 32'h0000_0003, 32'd0, 32'h8012_3456, 3);
    op(0, 3'd4, 32'h0000_0003, 32'd0, 32'h8012_3456, 1);
    op(0, 3'd1, 32'h0000_0002, 32'd0, 32'h8012_3456, 5);
    op(1, 3'd0, 32'h0000_C001, 32'h0000_00AB, 32'd0, 4);
    op(1, 3'd1, 32'h0000_C002, 32'h0000_1234, 32'd0, 2);
    op(0, 3'd2, 32'h0000_0006, 32'd0, 32'd0, 3);
    op(1, 3'd1, 32'h0000_0001, 32'h0000_1234, 32'd0, 3);
    op(0, 3'd2, 32'h0000_0010, 32'd0, 32'h1234_5678, 255);
    op(1, 3'd4, 32'h0000_0004, 32'h1111_2222, 32'd0, 3);

    // SW that never completes, reset pulled low in cycle 5.
    issue(1, 3'd2, 32'h0000_0020, 32'hCAFE_F00D, 32'd0, 255);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midbus_reset");
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk) check("no_done_after_reset", 32'(done), 32'd0);
    op(0, 3'd2, 32'h0000_0024, 32'd0, 32'h0BAD_CAFE, 6);

    for (int n = 0; n < 40; n++) begin
      bit [31:0] a;
      int d;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      d = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(1, 14));
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom, d);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size() + bus_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
